bus030_initiator: RTL and testbench
===================================

# bus030_initiator

Synchronous 68030-style bus master that turns a simple request/response interface into AS20/DS20/RW20/SIZ bus cycles terminated by STERM, including 4-beat cache-line burst reads via CBREQ/CBACK. It sits between an internal requester (DMA engine, test master, line-fill logic) and the accelerator-local bus, and it is the initiator counterpart of the fast-RAM responder on that bus.

## Interface
Parameters:
- TIMEOUT, 255: cycles without STERM/BERR before a cycle is aborted with ERR; must be at least 2.
- TO_W, 8: watchdog counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- CLK  in  1  bus clock; all logic is on the rising edge.
- RESET  in  1  reset, synchronous and active-low.
- REQ  in  1  request valid.
- ACK  out  1  one-cycle pulse; request accepted.
- REQ_A  in  32  byte address.
- REQ_RW  in  1  1 = read, 0 = write.
- REQ_SIZ  in  2  68030 SIZ encoding: 00 long, 01 byte, 10 word, 11 3-byte.
- REQ_BURST  in  1  request line burst; honoured only for long reads.
- REQ_WDATA  in  32  write data.
- RDATA  out  32  read data for the current beat.
- RVALID  out  1  RDATA valid, one cycle per beat.
- RLAST  out  1  final beat, qualified by RVALID.
- DONE  out  1  one-cycle pulse; bus cycle complete without error.
- ERR  out  1  one-cycle pulse; cycle aborted (BERR or timeout).
- A  out  32  bus address.
- SIZ  out  2  bus size.
- AS20, DS20  out  1  address and data strobes, active-low.
- RW20  out  1  1 = read.
- CBREQ  out  1  burst request, active-low.
- CBACK  in  1  burst acknowledge, active-low.
- CIIN  in  1  cache inhibit, active-low.
- STERM  in  1  synchronous termination, active-low.
- BERR  in  1  bus error, active-low.
- D_IN  in  32  bus read data.
- D_OUT  out  32  bus write data.
- D_OE  out  1  D_OUT drive enable.

## Operation
- FSM states: IDLE, ADDR, DATA, END, ABORT.
- IDLE: when REQ is high, pulse ACK. Latch the address, RW, size, and write data. Set the burst flag to REQ_BURST & REQ_RW & (REQ_SIZ==00). Go to ADDR.
- ADDR: drive A, SIZ, and RW20, and assert AS20=0. For reads, assert DS20=0 in the same cycle. Assert CBREQ=0 when the burst flag is set. For writes, drive D_OE=1 and D_OUT. Go to DATA.
- DATA: DS20=0 in every case (writes assert it one cycle after AS20). Sample STERM, BERR, CBACK, and CIIN on each rising edge.
  - BERR=0 has priority over STERM and goes to ABORT.
  - STERM=0 on a read captures D_IN into RDATA and pulses RVALID.
  - First beat: the cycle continues as a burst only if the burst flag is set, CBACK=0, and CIIN=1. Otherwise RLAST=1 and the FSM goes to END.
  - Burst beats: A[3:2] increments modulo 4 after each beat (wrap, starting at any alignment). A[31:4] and A[1:0] are held.
  - CBREQ is negated (1) from the edge that accepts the third beat.
  - The fourth beat sets RLAST and goes to END.
- END: AS20, DS20, and CBREQ are negated (1), D_OE=0, and DONE pulses. Return to IDLE. A new request is accepted no earlier than the following edge.
- ABORT: strobes and CBREQ are negated, D_OE=0, ERR pulses, and no RVALID is issued for that beat. Return to IDLE.
- Watchdog: cleared on entry to DATA and on every accepted beat, incremented every DATA cycle. When it reaches TIMEOUT, go to ABORT.
- Reset: takes effect on the next edge, including mid-burst with no further RVALID. Reset values:
  - AS20, DS20, CBREQ, and RW20 = 1.
  - A, SIZ, D_OUT, and RDATA = 0.
  - D_OE, ACK, RVALID, RLAST, DONE, and ERR = 0.
  - State is IDLE.

## Timing
- All outputs are registered; there are no combinational paths from bus inputs to outputs.
- Zero-wait single read: REQ at edge 0, ACK and strobes after edge 0. STERM is sampled low at edge 1, and RVALID, RLAST, and the END strobe negation take effect after edge 1. DONE follows after edge 2.
- Each wait cycle (STERM high) adds one cycle. A burst with zero wait states delivers beats on 4 consecutive edges.
- Write: DS20 asserts one cycle after AS20, so a zero-wait write terminates one cycle later than a read.
- STERM and BERR sampled low on the same edge: BERR wins, giving ERR with no RVALID.

## Structure
- Package bus030_pkg holds:
  - the FSM state enum;
  - SIZ encoding constants (SIZ_LONG, SIZ_BYTE, SIZ_WORD, SIZ_3BYTE);
  - the BEAT_MAX=4 constant and the 2-bit beat counter type.
- One sub-module, bus030_watchdog: a TO_W-bit counter with clear/enable inputs and a `expired` output.

## Test plan
- Long read at 0x00001000 with STERM low after 2 wait cycles and D_IN=0xDEADBEEF: one RVALID with RDATA=0xDEADBEEF, RLAST=1, and DONE; CBREQ stays high throughout.
- Burst read at 0x00002008 with CBACK=0 and CIIN=1, zero waits: 4 RVALIDs at A[3:2]=2,3,0,1, RLAST on the 4th, CBREQ high from the 3rd beat, and DONE.
- Burst read at 0x00002000 with CBACK=1 on the first STERM: a single RVALID with RLAST and DONE. Repeat with CBACK=0 and CIIN=0: the same single-beat result.
- Byte write of 0x000000A5 to 0x00003001 with SIZ=01: RW20=0, D_OE=1, D_OUT=0x000000A5, DS20 one cycle after AS20, DONE on termination.
- No STERM, TIMEOUT=8: ERR pulses 8 DATA cycles after entry, strobes negate, and there is no DONE or RVALID. Separately, BERR=0 with STERM=0 on the same edge: ERR only.
- RESET low during the 2nd burst beat: on the next edge AS20, DS20, and CBREQ = 1, D_OE=0, and no further RVALID; the next REQ after RESET releases runs normally.

Source files
------------

// File: rtl/bus030_pkg.sv
// bus030_pkg: shared types and constants for the 68030-style bus initiator.
package bus030_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, END, ABORT} state_e;
  localparam logic [1:0] SIZ_LONG  = 2'b00;
  localparam logic [1:0] SIZ_BYTE  = 2'b01;
  localparam logic [1:0] SIZ_WORD  = 2'b10;
  localparam logic [1:0] SIZ_3BYTE = 2'b11;
  localparam int BEAT_MAX = 4;
  typedef logic [1:0] beat_t;
  function automatic logic burst_ok(input logic burst, input logic rw, input logic [1:0] siz);
    return burst & rw & (siz == SIZ_LONG);
  endfunction
endpackage

// File: rtl/bus030_watchdog.sv
// bus030_watchdog: cycle counter flagging a stalled bus cycle.
module bus030_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int TO_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [TO_W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  // the cycle that would bring the count to TIMEOUT is the one that aborts
  assign expired = cnt_q == TO_W'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/bus030_initiator.sv
// bus030_initiator: request/response to AS20/DS20/STERM bus master with CBREQ line bursts.
module bus030_initiator
  import bus030_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  output logic        ACK,
  input  logic [31:0] REQ_A,
  input  logic        REQ_RW,
  input  logic [1:0]  REQ_SIZ,
  input  logic        REQ_BURST,
  input  logic [31:0] REQ_WDATA,
  output logic [31:0] RDATA,
  output logic        RVALID,
  output logic        RLAST,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] A,
  output logic [1:0]  SIZ,
  output logic        AS20,
  output logic        DS20,
  output logic        RW20,
  output logic        CBREQ,
  input  logic        CBACK,
  input  logic        CIIN,
  input  logic        STERM,
  input  logic        BERR,
  input  logic [31:0] D_IN,
  output logic [31:0] D_OUT,
  output logic        D_OE
);
  state_e state_q;
  beat_t  beat_q;
  logic   burst_q, rw_q, samp, hit, wd_exp, wd_to, abort_c, more_c, last_c;
  // reads have DS asserted from ADDR, so termination is sampled there too
  assign samp    = state_q == DATA || (state_q == ADDR && rw_q);
  assign wd_to   = state_q == DATA && wd_exp;
  assign hit     = samp && BERR && !STERM;
  assign abort_c = samp && (!BERR || (wd_to && STERM));
  assign more_c  = hit && (beat_q == '0 ? burst_q && !CBACK && CIIN : beat_q != beat_t'(BEAT_MAX - 1));
  assign last_c  = hit && !more_c;
  bus030_watchdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_wd (
    .clk(CLK), .rst_n(RESET), .clr(state_q == ADDR || hit), .en(state_q == DATA), .expired(wd_exp)
  );
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      beat_q  <= '0;
      burst_q <= 1'b0;
      rw_q    <= 1'b1;
      AS20    <= 1'b1;
      DS20    <= 1'b1;
      CBREQ   <= 1'b1;
      RW20    <= 1'b1;
      A       <= '0;
      SIZ     <= '0;
      D_OUT   <= '0;
      RDATA   <= '0;
      D_OE    <= 1'b0;
      ACK     <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      ACK    <= 1'b0;
      RVALID <= 1'b0;
      RLAST  <= 1'b0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
      case (state_q)
        IDLE: if (REQ) begin
          ACK     <= 1'b1;
          A       <= REQ_A;
          SIZ     <= REQ_SIZ;
          RW20    <= REQ_RW;
          rw_q    <= REQ_RW;
          D_OUT   <= REQ_WDATA;
          burst_q <= burst_ok(REQ_BURST, REQ_RW, REQ_SIZ);
          beat_q  <= '0;
          AS20    <= 1'b0;
          DS20    <= !REQ_RW;
          CBREQ   <= !burst_ok(REQ_BURST, REQ_RW, REQ_SIZ);
          D_OE    <= !REQ_RW;
          state_q <= ADDR;
        end
        ADDR, DATA: if (!samp) begin
          DS20    <= 1'b0;
          state_q <= DATA;
        end else begin
          state_q <= abort_c ? ABORT : last_c ? END : DATA;
          RLAST   <= last_c && rw_q;
          if (hit && rw_q) begin
            RDATA  <= D_IN;
            RVALID <= 1'b1;
          end
          if (more_c) begin
            A[3:2] <= A[3:2] + 2'd1;
            beat_q <= beat_q + 2'd1;
          end
          if (more_c && beat_q == 2'd2) CBREQ <= 1'b1;
        end
        END: begin
          DONE    <= 1'b1;
          state_q <= IDLE;
        end
        ABORT: begin
          ERR     <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (abort_c || last_c) begin
        AS20  <= 1'b1;
        DS20  <= 1'b1;
        CBREQ <= 1'b1;
        D_OE  <= 1'b0;
        RW20  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bus030_initiator.sv
// tb_bus030_initiator: directed bus cycles checked cycle-by-cycle against a timeline model.
module tb_bus030_initiator;
  localparam int TO = 8;
  localparam int NC = 40;
  logic CLK = 1'b0, RESET = 1'b0, REQ = 1'b0, REQ_RW = 1'b0, REQ_BURST = 1'b0;
  logic CBACK = 1'b1, CIIN = 1'b1, STERM = 1'b1, BERR = 1'b1;
  logic [31:0] REQ_A = '0, REQ_WDATA = '0, D_IN = '0;
  logic [1:0] REQ_SIZ = '0;
  logic ACK, RVALID, RLAST, DONE, ERR, AS20, DS20, RW20, CBREQ, D_OE;
  logic [31:0] RDATA, A, D_OUT;
  logic [1:0] SIZ;

  always #5 CLK = ~CLK;

  bus030_initiator #(.TIMEOUT(TO), .TO_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .ACK(ACK), .REQ_A(REQ_A), .REQ_RW(REQ_RW),
    .REQ_SIZ(REQ_SIZ), .REQ_BURST(REQ_BURST), .REQ_WDATA(REQ_WDATA), .RDATA(RDATA),
    .RVALID(RVALID), .RLAST(RLAST), .DONE(DONE), .ERR(ERR), .A(A), .SIZ(SIZ),
    .AS20(AS20), .DS20(DS20), .RW20(RW20), .CBREQ(CBREQ), .CBACK(CBACK), .CIIN(CIIN),
    .STERM(STERM), .BERR(BERR), .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE)
  );

  int n_run = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // expected timeline, indexed by clock edges since the accepting edge
  logic e_act[NC], e_ack[NC], e_as[NC], e_ds[NC], e_cb[NC], e_oe[NC];
  logic e_rv[NC], e_rl[NC], e_done[NC], e_err[NC];
  logic [31:0] e_rd[NC], e_a[NC];
  logic [31:0] m_wdata, m_data[4];
  logic [1:0] m_siz;
  logic m_rw, m_bflag, m_abort;
  int m_e[4], m_nb, m_beats, m_term;
  int cyc = 0;
  bit chk_en = 0;
  int rv_cnt, rv_cyc, done_cyc, err_cyc, as_cyc, ds_cyc;
  logic [31:0] rv_data;
  logic [1:0] a_seq[$];

  always @(negedge CLK) if (chk_en) begin
    chk("ack", ACK, e_ack[cyc]);
    chk("as20", AS20, e_as[cyc]);
    chk("ds20", DS20, e_ds[cyc]);
    chk("cbreq", CBREQ, e_cb[cyc]);
    chk("d_oe", D_OE, e_oe[cyc]);
    chk("rvalid", RVALID, e_rv[cyc]);
    chk("rlast", RLAST, e_rl[cyc]);
    chk("done", DONE, e_done[cyc]);
    chk("err", ERR, e_err[cyc]);
    if (e_rv[cyc]) chk("rdata", RDATA, e_rd[cyc]);
    if (e_act[cyc]) begin
      chk("addr", A, e_a[cyc]);
      chk("siz", SIZ, m_siz);
      chk("rw20", RW20, m_rw);
      if (!m_rw) chk("d_out", D_OUT, m_wdata);
    end
    if (RVALID) begin rv_cnt++; rv_cyc = cyc; rv_data = RDATA; end
    if (DONE) done_cyc = cyc;
    if (ERR) err_cyc = cyc;
    if (!AS20 && as_cyc < 0) as_cyc = cyc;
    if (!DS20 && ds_cyc < 0) ds_cyc = cyc;
  end

  task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [1:0] siz,
                         input logic burst, input logic [31:0] wdata,
                         input int w0, input int w1, input int w2, input int w3,
                         input logic cback, input logic ciin, input int berr_b, input bit to,
                         input logic [31:0] d0);
    int w[4];
    int cnt, last;
    logic act;
    w = '{w0, w1, w2, w3};
    m_rw = rw; m_siz = siz; m_wdata = wdata;
    m_bflag = burst && rw && siz == 2'b00;
    m_nb = (m_bflag && !cback && ciin) ? 4 : 1;
    for (int j = 0; j < 4; j++) begin
      m_e[j] = (j == 0 ? (rw ? 1 : 2) : m_e[j-1] + 1) + w[j];
      m_data[j] = d0 + 32'h0101_0101 * j;
    end
    if (to) begin m_term = 1 + TO; m_beats = 0; m_abort = 1; end
    else if (berr_b >= 0) begin m_term = m_e[berr_b]; m_beats = berr_b; m_abort = 1; end
    else begin m_term = m_e[m_nb-1]; m_beats = m_nb; m_abort = 0; end
    for (int k = 0; k < NC; k++) begin
      act = k < m_term;
      e_act[k] = act;
      e_ack[k] = k == 0;
      e_as[k] = !act;
      e_ds[k] = !(act && (rw || k >= 1));
      e_oe[k] = act && !rw;
      e_cb[k] = !(act && m_bflag && !(m_nb == 4 && k >= m_e[2]));
      e_rv[k] = 0; e_rl[k] = 0; e_rd[k] = '0; cnt = 0;
      for (int j = 0; j < m_beats; j++) begin
        if (rw && m_e[j] == k) begin e_rv[k] = 1; e_rl[k] = j == m_nb - 1; e_rd[k] = m_data[j]; end
        if (m_e[j] <= k) cnt++;
      end
      e_a[k] = {addr[31:4], addr[3:2] + cnt[1:0], addr[1:0]};
      e_done[k] = !m_abort && k == m_term + 1;
      e_err[k] = m_abort && k == m_term + 1;
    end
    last = m_term + 3;
    rv_cnt = 0; rv_cyc = -1; done_cyc = -1; err_cyc = -1; as_cyc = -1; ds_cyc = -1; rv_data = '0;
    a_seq.delete();
    @(negedge CLK);
    REQ = 1; REQ_RW = rw; REQ_A = addr; REQ_SIZ = siz; REQ_BURST = burst; REQ_WDATA = wdata;
    CBACK = cback; CIIN = ciin; STERM = 1; BERR = 1;
    @(posedge CLK);
    cyc = 0; chk_en = 1;
    for (int k = 1; k <= last; k++) begin
      @(negedge CLK);
      REQ = 0; STERM = 1; BERR = 1; D_IN = 32'h0BAD_0000 | k;
      if (!to) for (int j = 0; j < m_nb; j++)
        if (k == m_e[j] && (berr_b < 0 || j <= berr_b)) begin
          STERM = 0; D_IN = m_data[j]; a_seq.push_back(A[3:2]);
        end
      if (berr_b >= 0 && !to && k == m_e[berr_b]) BERR = 0;
      @(posedge CLK);
      cyc = k;
    end
    @(negedge CLK);
    #1 chk_en = 0;
    STERM = 1; BERR = 1; CBACK = 1; CIIN = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_a[4];
    int rvs;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_as20", AS20, 1); chk("rst_ds20", DS20, 1); chk("rst_cbreq", CBREQ, 1);
    chk("rst_rw20", RW20, 1); chk("rst_a", A, 0); chk("rst_siz", SIZ, 0);
    chk("rst_dout", D_OUT, 0); chk("rst_rdata", RDATA, 0); chk("rst_doe", D_OE, 0);
    chk("rst_ack", ACK, 0); chk("rst_rvalid", RVALID, 0); chk("rst_rlast", RLAST, 0);
    chk("rst_done", DONE, 0); chk("rst_err", ERR, 0);
    @(negedge CLK); RESET = 1;

    run_txn(1, 32'h0000_1000, 2'b00, 0, 0, 2, 0, 0, 0, 1, 1, -1, 0, 32'hDEAD_BEEF);
    chk("t1_rv_cyc", rv_cyc, 3); chk("t1_done_cyc", done_cyc, 4);
    chk("t1_rdata", rv_data, 32'hDEAD_BEEF); chk("t1_rv_cnt", rv_cnt, 1);

    run_txn(1, 32'h0000_2008, 2'b00, 1, 0, 0, 0, 0, 0, 0, 1, -1, 0, 32'h1111_0000);
    exp_a = '{2'd2, 2'd3, 2'd0, 2'd1};
    chk("t2_rv_cnt", rv_cnt, 4); chk("t2_done_cyc", done_cyc, 5); chk("t2_a_cnt", a_seq.size(), 4);
    for (int i = 0; i < 4 && i < a_seq.size(); i++) chk("t2_a32", a_seq[i], exp_a[i]);

    run_txn(1, 32'h0000_2000, 2'b00, 1, 0, 0, 0, 0, 0, 1, 1, -1, 0, 32'h2222_0000);
    chk("t3_rv_cnt", rv_cnt, 1); chk("t3_done_cyc", done_cyc, 2);
    run_txn(1, 32'h0000_2000, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, -1, 0, 32'h3333_0000);
    chk("t4_rv_cnt", rv_cnt, 1); chk("t4_done_cyc", done_cyc, 2);

    run_txn(0, 32'h0000_3001, 2'b01, 0, 32'h0000_00A5, 0, 0, 0, 0, 1, 1, -1, 0, 0);
    chk("t5_as_cyc", as_cyc, 0); chk("t5_ds_cyc", ds_cyc, 1);
    chk("t5_done_cyc", done_cyc, 3); chk("t5_rv_cnt", rv_cnt, 0);

    run_txn(1, 32'h0000_4000, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, -1, 1, 0);
    chk("t6_err_cyc", err_cyc, 10); chk("t6_no_done", done_cyc, 32'hFFFF_FFFF); chk("t6_rv_cnt", rv_cnt, 0);

    run_txn(1, 32'h0000_4100, 2'b00, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 32'h4444_0000);
    chk("t7_err_cyc", err_cyc, 3); chk("t7_rv_cnt", rv_cnt, 0); chk("t7_no_done", done_cyc, 32'hFFFF_FFFF);

    run_txn(1, 32'h0000_400C, 2'b00, 1, 0, 1, 0, 2, 1, 0, 1, -1, 0, 32'h5555_0000);
    exp_a = '{2'd3, 2'd0, 2'd1, 2'd2};
    chk("t8_rv_cnt", rv_cnt, 4); chk("t8_done_cyc", done_cyc, 9);
    for (int i = 0; i < 4 && i < a_seq.size(); i++) chk("t8_a32", a_seq[i], exp_a[i]);

    run_txn(0, 32'h0000_5002, 2'b10, 0, 32'h1234_5678, 2, 0, 0, 0, 1, 1, -1, 0, 0);
    chk("t9_done_cyc", done_cyc, 5);

    run_txn(1, 32'h0000_6004, 2'b00, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 32'h6666_0000);
    chk("t10_rv_cnt", rv_cnt, 2); chk("t10_err_cyc", err_cyc, 4);

    @(negedge CLK);
    REQ = 1; REQ_RW = 1; REQ_A = 32'h0000_2008; REQ_SIZ = 2'b00; REQ_BURST = 1; CBACK = 0; CIIN = 1;
    @(negedge CLK);
    REQ = 0; STERM = 0; D_IN = 32'hAAAA_0001;
    @(negedge CLK);
    RESET = 0; D_IN = 32'hAAAA_0002;
    @(posedge CLK);
    #1;
    chk("rst_mid_as20", AS20, 1); chk("rst_mid_ds20", DS20, 1); chk("rst_mid_cbreq", CBREQ, 1);
    chk("rst_mid_doe", D_OE, 0); chk("rst_mid_rvalid", RVALID, 0); chk("rst_mid_rdata", RDATA, 0);
    @(negedge CLK);
    RESET = 1;
    rvs = 0;
    repeat (3) begin
      @(posedge CLK);
      #1 if (RVALID) rvs++;
    end
    chk("rst_mid_no_rvalid", rvs, 0); chk("rst_mid_idle_as20", AS20, 1);
    @(negedge CLK);
    STERM = 1; CBACK = 1;

    run_txn(1, 32'h0000_7000, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, -1, 0, 32'h7777_0000);
    chk("t12_rv_cyc", rv_cyc, 1); chk("t12_done_cyc", done_cyc, 2); chk("t12_rdata", rv_data, 32'h7777_0000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
